// File: rtl/writeback_stage_pkg.sv
// Shared pipeline stage-register types and defaults for the writeback stage.
// The EX/WB register layout lives here so the execute and writeback stages use the same definition.
package writeback_stage_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int REG_AW       = 5;

  typedef struct packed {
    logic [XLEN_DEF-1:0] alu_result;
    logic                alu_result_ready;
    logic                do_not_execute;
    logic [REG_AW-1:0]   reg_wr_addr;
    logic                rd_wr_en;
  } ex_wb_t;

  // A slot retires when its result is ready and it was not squashed.
  function automatic logic slot_retires(input ex_wb_t e);
    return e.alu_result_ready & ~e.do_not_execute;
  endfunction

  // A retiring slot writes only when it targets a real (non-x0) register.
  function automatic logic slot_writes(input ex_wb_t e);
    return slot_retires(e) & e.rd_wr_en & (e.reg_wr_addr != 5'd0);
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Bus between the pipeline (master) and the writeback stage (slave):
// EX/WB register in, register-file read ports and retire trace out.
interface writeback_stage_if
  import writeback_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) ();

  ex_wb_t            ex_wb_r;
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic [63:0]       instret;

  modport master (
    output ex_wb_r, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, wb_valid, wb_addr, wb_data, instret
  );

  modport slave (
    input  ex_wb_r, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, wb_valid, wb_addr, wb_data, instret
  );

endinterface

// File: rtl/writeback_stage_register_file.sv
// Architectural register file: two combinational read ports, one write port,
// x0 hardwired to zero, every entry cleared asynchronously on reset.
module register_file
  import writeback_stage_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [REG_AW-1:0] raddr_a_i,
  output logic [XLEN-1:0]   rdata_a_o,
  input  logic [REG_AW-1:0] raddr_b_i,
  output logic [XLEN-1:0]   rdata_b_o
);

  logic [XLEN-1:0] regs_q [NUM_REGS];

  // Storage update; reset wins over any write pending at the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Combinational read ports with x0 forced to zero.
  always_comb begin
    rdata_a_o = '0;
    rdata_b_o = '0;
    if (raddr_a_i != 5'd0) begin
      rdata_a_o = regs_q[raddr_a_i];
    end else begin
      rdata_a_o = '0;
    end
    if (raddr_b_i != 5'd0) begin
      rdata_b_o = regs_q[raddr_b_i];
    end else begin
      rdata_b_o = '0;
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: commits EX/WB results to the register file, bypasses the
// in-flight write onto both read ports, and keeps the retire trace and instret.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  writeback_stage_if.slave  bus
);

  logic              wr_fire_s;
  logic              retire_s;
  logic [XLEN-1:0]   rf_a_s;
  logic [XLEN-1:0]   rf_b_s;

  logic              wb_valid_q, wb_valid_d;
  logic [REG_AW-1:0] wb_addr_q,  wb_addr_d;
  logic [XLEN-1:0]   wb_data_q,  wb_data_d;
  logic [63:0]       instret_q,  instret_d;

  assign wr_fire_s = slot_writes(bus.ex_wb_r);
  assign retire_s  = slot_retires(bus.ex_wb_r);

  register_file #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_register_file (
    .clk       (clk),
    .reset_n   (reset_n),
    .we_i      (wr_fire_s),
    .waddr_i   (bus.ex_wb_r.reg_wr_addr),
    .wdata_i   (bus.ex_wb_r.alu_result),
    .raddr_a_i (bus.rs1_addr),
    .rdata_a_o (rf_a_s),
    .raddr_b_i (bus.rs2_addr),
    .rdata_b_o (rf_b_s)
  );

  // Same-cycle bypass; wr_fire already excludes x0, so x0 never bypasses.
  always_comb begin
    bus.rs1_data = rf_a_s;
    bus.rs2_data = rf_b_s;
    if (wr_fire_s && (bus.rs1_addr == bus.ex_wb_r.reg_wr_addr)) begin
      bus.rs1_data = bus.ex_wb_r.alu_result;
    end else begin
      bus.rs1_data = rf_a_s;
    end
    if (wr_fire_s && (bus.rs2_addr == bus.ex_wb_r.reg_wr_addr)) begin
      bus.rs2_data = bus.ex_wb_r.alu_result;
    end else begin
      bus.rs2_data = rf_b_s;
    end
  end

  // Next-state for trace (address/data hold when idle) and the retire counter.
  always_comb begin
    wb_valid_d = wr_fire_s;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    instret_d  = instret_q;
    if (wr_fire_s) begin
      wb_addr_d = bus.ex_wb_r.reg_wr_addr;
      wb_data_d = bus.ex_wb_r.alu_result;
    end else begin
      wb_addr_d = wb_addr_q;
      wb_data_d = wb_data_q;
    end
    if (retire_s) begin
      instret_d = instret_q + 64'd1;
    end else begin
      instret_d = instret_q;
    end
  end

  // Trace and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      instret_q  <= 64'd0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      instret_q  <= instret_d;
    end
  end

  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_addr  = wb_addr_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.instret  = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus random
// traffic compared against an array-based architectural model.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  writeback_stage_if bus ();

  writeback_stage dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_regs [32];
  logic [63:0] m_instret;
  logic        m_wb_valid;
  logic [4:0]  m_wb_addr;
  logic [31:0] m_wb_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic ex_wb_t mk(input logic rdy, input logic dne, input logic wen,
                                input logic [4:0] addr, input logic [31:0] data);
    ex_wb_t e;
    e.alu_result       = data;
    e.alu_result_ready = rdy;
    e.do_not_execute   = dne;
    e.rd_wr_en         = wen;
    e.reg_wr_addr      = addr;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_instret  = 64'd0;
    m_wb_valid = 1'b0;
    m_wb_addr  = 5'd0;
    m_wb_data  = 32'd0;
  endtask

  // Architectural view: what an instruction reading reg 'a' this cycle sees.
  function automatic logic [31:0] m_read(input logic [4:0] a, input ex_wb_t e);
    bit writes;
    writes = (e.alu_result_ready == 1'b1) && (e.do_not_execute == 1'b0) &&
             (e.rd_wr_en == 1'b1) && (e.reg_wr_addr != 5'd0);
    if (a == 5'd0) return 32'd0;
    if (writes && (a == e.reg_wr_addr)) return e.alu_result;
    return m_regs[a];
  endfunction

  task automatic drive(input ex_wb_t e, input logic [4:0] a1, input logic [4:0] a2);
    bus.ex_wb_r  = e;
    bus.rs1_addr = a1;
    bus.rs2_addr = a2;
  endtask

  // One clock: check reads before the edge, advance the model, check state after.
  task automatic cycle(input string tag);
    ex_wb_t e;
    bit     retired;
    bit     wrote;
    e = bus.ex_wb_r;
    #1;
    check({tag, ".rs1"}, bus.rs1_data, m_read(bus.rs1_addr, e));
    check({tag, ".rs2"}, bus.rs2_data, m_read(bus.rs2_addr, e));
    @(posedge clk);
    retired = e.alu_result_ready && !e.do_not_execute;
    wrote   = retired && e.rd_wr_en && (e.reg_wr_addr != 5'd0);
    if (wrote) begin
      m_regs[e.reg_wr_addr] = e.alu_result;
      m_wb_addr = e.reg_wr_addr;
      m_wb_data = e.alu_result;
    end
    m_wb_valid = wrote;
    if (retired) m_instret = m_instret + 64'd1;
    #1;
    check({tag, ".wb_valid"}, bus.wb_valid, m_wb_valid);
    check({tag, ".wb_addr"},  bus.wb_addr,  m_wb_addr);
    check({tag, ".wb_data"},  bus.wb_data,  m_wb_data);
    check({tag, ".instret"},  bus.instret,  m_instret);
  endtask

  initial begin
    logic [63:0] prev;
    ex_wb_t idle;
    idle = mk(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    model_reset();
    drive(idle, 5'd5, 5'd9);
    #3;
    check("rst.rs1", bus.rs1_data, 32'd0);
    check("rst.wb_valid", bus.wb_valid, 1'b0);
    check("rst.instret", bus.instret, 64'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // First edge after reset release performs a write
    drive(mk(1'b1, 1'b0, 1'b1, 5'd5, 32'h12345678), 5'd0, 5'd0);
    cycle("x5_wr");
    check("x5_wr.wb_valid_c", bus.wb_valid, 1'b1);
    check("x5_wr.wb_addr_c",  bus.wb_addr,  5'd5);
    drive(idle, 5'd5, 5'd0);
    #1 check("x5_rd.c", bus.rs1_data, 32'h12345678);
    cycle("x5_rd");

    drive(mk(1'b1, 1'b0, 1'b1, 5'd7, 32'hCAFEF00D), 5'd7, 5'd7);
    #1;
    check("byp7.rs1_c", bus.rs1_data, 32'hCAFEF00D);
    check("byp7.rs2_c", bus.rs2_data, 32'hCAFEF00D);
    cycle("byp7");

    prev = m_instret;
    drive(mk(1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF), 5'd0, 5'd0);
    cycle("x0_wr");
    check("x0_wr.rs1_c", bus.rs1_data, 32'd0);
    check("x0_wr.valid_c", bus.wb_valid, 1'b0);
    check("x0_wr.instret_c", bus.instret, prev + 64'd1);

    drive(mk(1'b1, 1'b0, 1'b1, 5'd3, 32'h00000011), 5'd0, 5'd0);
    cycle("x3_pre");
    prev = m_instret;
    drive(mk(1'b1, 1'b1, 1'b1, 5'd3, 32'hDEADBEEF), 5'd3, 5'd3);
    #1 check("squash.nobyp_c", bus.rs1_data, 32'h00000011);
    cycle("squash");
    check("squash.instret_c", bus.instret, prev);
    drive(idle, 5'd3, 5'd0);
    #1 check("squash.x3_c", bus.rs1_data, 32'h00000011);
    cycle("squash_rd");

    drive(mk(1'b0, 1'b0, 1'b1, 5'd4, 32'h0BADF00D), 5'd4, 5'd4);
    cycle("notready");

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      logic [4:0] wa;
      wa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      drive(mk(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
               1'($urandom_range(0, 9) < 7), wa, $urandom),
            ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)));
      cycle("rand");
    end

    // Counter wrap
    drive(idle, 5'd0, 5'd0);
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.instret_q;
    m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 check("wrap.pre", bus.instret, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(mk(1'b1, 1'b0, 1'b0, 5'd0, 32'd0), 5'd0, 5'd0);
    cycle("wrap");
    check("wrap.zero_c", bus.instret, 64'd0);

    // Asynchronous reset mid-cycle
    drive(mk(1'b1, 1'b0, 1'b1, 5'd9, 32'hA5A5A5A5), 5'd0, 5'd0);
    cycle("x9_wr");
    drive(idle, 5'd9, 5'd9);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("arst.x9", bus.rs1_data, 32'd0);
    check("arst.instret", bus.instret, 64'd0);
    check("arst.wb_valid", bus.wb_valid, 1'b0);
    check("arst.wb_addr", bus.wb_addr, 5'd0);
    check("arst.wb_data", bus.wb_data, 32'd0);
    drive(mk(1'b1, 1'b0, 1'b1, 5'd9, 32'h00000077), 5'd0, 5'd0);
    @(posedge clk);
    #1 drive(idle, 5'd9, 5'd0);
    #1;
    check("arst.lost_wr", bus.rs1_data, 32'd0);
    check("arst.lost_instret", bus.instret, 64'd0);
    reset_n = 1'b1;
    #1;
    @(posedge clk);
    #1;
    drive(mk(1'b1, 1'b0, 1'b1, 5'd10, 32'h13579BDF), 5'd10, 5'd9);
    cycle("post_rst");
    for (int n = 0; n < 40; n++) begin
      drive(mk(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0), 1'b1,
               5'($urandom_range(0, 31)), $urandom),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      cycle("rand2");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
